// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep reader.
// The state enum is exported so the top can expose it for debug.
package tt_pkg;

    localparam int N_INPUTS_DEF = 4;
    localparam int TT_WIDTH     = 16;
    localparam int SETTLE_W     = 8;

    typedef logic [N_INPUTS_DEF-1:0] idx_t;
    typedef logic [SETTLE_W-1:0]     settle_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Counts the extra hold cycles a vector spends in APPLY.
// done pulses on the last APPLY cycle so the FSM moves to SAMPLE next.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam settle_cnt_t TERM = (SETTLE_CYCLES == 0) ? settle_cnt_t'(0)
                                                        : settle_cnt_t'(SETTLE_CYCLES - 1);

    settle_cnt_t cnt_q;
    settle_cnt_t cnt_d;

    always_comb begin
        done  = en && (cnt_q == TERM);
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !done) begin
            cnt_d = cnt_q + settle_cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_sweep_reader.sv
// Walks every input combination of a gate, records its output per vector
// and compares the captured truth table against an expected one.
module tt_sweep_reader
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_INPUTS      = N_INPUTS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [(1<<N_INPUTS)-1:0] expect_tt,
    output logic [N_INPUTS-1:0]      dut_in,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [(1<<N_INPUTS)-1:0] tt_value,
    output logic                     match,
    output logic [(1<<N_INPUTS)-1:0] mismatch_mask,
    output state_e                   state_dbg
);

    localparam int TT_W = 1 << N_INPUTS;
    localparam logic [N_INPUTS-1:0] LAST_IDX = '1;
    // With no settle cycles each vector lives only in SAMPLE.
    localparam state_e VEC_ST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_APPLY;

    state_e              state_q, state_d;
    logic [N_INPUTS-1:0] idx_q, idx_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic [TT_W-1:0]     exp_q, exp_d;
    logic [TT_W-1:0]     mask_q, mask_d;
    logic                match_q, match_d;
    logic                settle_load;
    logic                settle_en;
    logic                settle_done;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk (clk),
        .rst (rst),
        .load(settle_load),
        .en  (settle_en),
        .done(settle_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = VEC_ST;
            ST_APPLY:  if (settle_done) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (idx_q == LAST_IDX) ? ST_DONE : VEC_ST;
            ST_DONE:   if (result_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        settle_load  = (state_d == ST_APPLY) && (state_q != ST_APPLY);
        settle_en    = (state_q == ST_APPLY);
        busy         = (state_q != ST_IDLE);
        result_valid = (state_q == ST_DONE);
        dut_in       = '0;
        if (state_q == ST_APPLY || state_q == ST_SAMPLE) begin
            dut_in = idx_q;
        end
        tt_value      = tt_q;
        match         = match_q;
        mismatch_mask = mask_q;
        state_dbg     = state_q;
    end

    always_comb begin
        idx_d   = idx_q;
        tt_d    = tt_q;
        exp_d   = exp_q;
        match_d = match_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = expect_tt;
                    tt_d    = '0;
                    idx_d   = '0;
                    match_d = 1'b0;
                    mask_d  = '0;
                end
            end
            ST_SAMPLE: begin
                tt_d[idx_q] = dut_out;
                // The index parks at the last vector; DONE is taken instead of wrapping.
                if (idx_q == LAST_IDX) begin
                    match_d = (tt_d == exp_q);
                    mask_d  = tt_d ^ exp_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Bench for tt_sweep_reader: one instance with two settle cycles, one with none,
// each driving a behavioural gate whose truth table lives in model_tt.
module tb_tt_sweep_reader;
    import tt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] expect_tt = 16'h0000;
    logic [15:0] model_tt = 16'h1858;

    logic        start2, start0, ready2, ready0;
    logic [3:0]  dut_in2, dut_in0;
    logic        dut_out2, dut_out0;
    logic        busy2, busy0, valid2, valid0, match2, match0;
    logic [15:0] tt2, tt0, mask2, mask0;
    state_e      st2, st0;

    assign start2 = start & ~sel;
    assign start0 = start & sel;
    assign ready2 = ready & ~sel;
    assign ready0 = ready & sel;
    assign dut_out2 = model_tt[dut_in2];
    assign dut_out0 = model_tt[dut_in0];

    tt_sweep_reader #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .expect_tt(expect_tt),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2),
        .result_valid(valid2), .result_ready(ready2), .tt_value(tt2),
        .match(match2), .mismatch_mask(mask2), .state_dbg(st2)
    );

    tt_sweep_reader #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .expect_tt(expect_tt),
        .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0),
        .result_valid(valid0), .result_ready(ready0), .tt_value(tt0),
        .match(match0), .mismatch_mask(mask0), .state_dbg(st0)
    );

    logic [3:0]  o_dut_in;
    logic        o_busy, o_valid, o_match;
    logic [15:0] o_tt, o_mask;
    assign o_dut_in = sel ? dut_in0 : dut_in2;
    assign o_busy   = sel ? busy0 : busy2;
    assign o_valid  = sel ? valid0 : valid2;
    assign o_match  = sel ? match0 : match2;
    assign o_tt     = sel ? tt0 : tt2;
    assign o_mask   = sel ? mask0 : mask2;

    int total = 0;
    int bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] last_e;

    task automatic check_idle_zero(input string tag);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL %s busy got=%0b want=0", tag, o_busy); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s valid got=%0b want=0", tag, o_valid); end
        total++; if (o_dut_in !== 4'h0) begin bad++; $display("FAIL %s dut_in got=%0h want=0", tag, o_dut_in); end
        total++; if (o_tt !== 16'h0000) begin bad++; $display("FAIL %s tt got=%h want=0000", tag, o_tt); end
        total++; if (o_match !== 1'b0) begin bad++; $display("FAIL %s match got=%0b want=0", tag, o_match); end
        total++; if (o_mask !== 16'h0000) begin bad++; $display("FAIL %s mask got=%h want=0000", tag, o_mask); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        expect_tt = 16'h1858;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        check_idle_zero("reset_s2");
        total++; if (st2 !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", st2, ST_IDLE); end
        sel = 1'b1;
        #1;
        check_idle_zero("reset_s0");
        rst = 1'b0;
        start = 1'b0;
        sel = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep from IDLE, checks every driven vector and latency, then
    // compares the result against the scoreboard. Leaves the DUT in DONE.
    task automatic do_sweep(input logic [15:0] etl, input bit disturb);
        int s;
        int cnt;
        logic [32:0] e;
        s = sel ? 0 : 2;
        exp_q.push_back({(model_tt == etl), model_tt ^ etl, model_tt});
        expect_tt = etl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        while (o_valid !== 1'b1 && cnt < 400) begin
            if (cnt < 16 * (s + 1)) begin
                total++;
                if (o_dut_in !== 4'(cnt / (s + 1))) begin
                    bad++;
                    $display("FAIL sweep_dut_in cyc=%0d got=%0h want=%0h", cnt, o_dut_in, 4'(cnt / (s + 1)));
                end
            end
            total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL sweep_busy cyc=%0d got=%0b want=1", cnt, o_busy); end
            start = disturb && (cnt == 7 * (s + 1));
            if (start) expect_tt = ~etl;
            @(posedge clk);
            #1;
            cnt++;
        end
        start = 1'b0;
        total++;
        if (cnt != 16 * (s + 1)) begin
            bad++;
            $display("FAIL sweep_latency got=%0d want=%0d", cnt, 16 * (s + 1));
        end
        e = exp_q.pop_front();
        last_e = e;
        total++; if (o_tt !== e[15:0]) begin bad++; $display("FAIL result_tt got=%h want=%h", o_tt, e[15:0]); end
        total++; if (o_mask !== e[31:16]) begin bad++; $display("FAIL result_mask got=%h want=%h", o_mask, e[31:16]); end
        total++; if (o_match !== e[32]) begin bad++; $display("FAIL result_match got=%0b want=%0b", o_match, e[32]); end
        total++; if (o_dut_in !== 4'h0) begin bad++; $display("FAIL done_dut_in got=%0h want=0", o_dut_in); end
    endtask

    task automatic finish_result();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL handshake_busy got=%0b want=0", o_busy); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL handshake_valid got=%0b want=0", o_valid); end
        total++; if (o_tt !== last_e[15:0]) begin bad++; $display("FAIL retain_tt got=%h want=%h", o_tt, last_e[15:0]); end
        total++; if (o_match !== last_e[32]) begin bad++; $display("FAIL retain_match got=%0b want=%0b", o_match, last_e[32]); end
        total++; if (o_mask !== last_e[31:16]) begin bad++; $display("FAIL retain_mask got=%h want=%h", o_mask, last_e[31:16]); end
    endtask

    task automatic test_match();
        sel = 1'b0;
        model_tt = 16'h1858;
        do_sweep(16'h1858, 1'b0);
        finish_result();
    endtask

    task automatic test_mismatch();
        sel = 1'b0;
        model_tt = 16'h1858;
        do_sweep(16'h1859, 1'b0);
        finish_result();
    endtask

    task automatic test_settle0();
        sel = 1'b1;
        model_tt = 16'h1858;
        do_sweep(16'h1858, 1'b0);
        finish_result();
        sel = 1'b0;
    endtask

    task automatic test_hold_and_ignore();
        sel = 1'b0;
        model_tt = 16'h1858;
        do_sweep(16'h1858, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%0b want=1", i, o_valid); end
            total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL hold_busy cyc=%0d got=%0b want=1", i, o_busy); end
            total++; if (o_tt !== 16'h1858) begin bad++; $display("FAIL hold_tt cyc=%0d got=%h want=1858", i, o_tt); end
            total++; if (o_match !== 1'b1) begin bad++; $display("FAIL hold_match cyc=%0d got=%0b want=1", i, o_match); end
            total++; if (o_mask !== 16'h0000) begin bad++; $display("FAIL hold_mask cyc=%0d got=%h want=0000", i, o_mask); end
            start = (i == 2);
            if (start) expect_tt = 16'h0000;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        finish_result();
        @(posedge clk);
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL no_restart_busy got=%0b want=0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int guard;
        sel = 1'b0;
        model_tt = 16'h1858;
        expect_tt = 16'h1858;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (o_dut_in !== 4'd9 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++; if (guard >= 100) begin bad++; $display("FAIL reach_vec9 got=%0h want=9", o_dut_in); end
        rst = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b0;
        check_idle_zero("mid_reset");
        total++; if (st2 !== ST_IDLE) begin bad++; $display("FAIL mid_reset_state got=%0d want=%0d", st2, ST_IDLE); end
        do_sweep(16'h1858, 1'b0);
        finish_result();
    endtask

    task automatic test_back_to_back();
        logic [15:0] etl;
        for (int i = 0; i < 4; i++) begin
            sel = 1'($urandom_range(0, 1));
            model_tt = 16'($urandom_range(0, 65535));
            etl = model_tt;
            if (i % 2 == 1) etl = model_tt ^ (16'h0001 << $urandom_range(0, 15));
            do_sweep(etl, 1'b0);
            finish_result();
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_settle0();
        test_hold_and_ignore();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
